ram_2port_arbiter: RTL and testbench
====================================

# ram_2port_arbiter

Single-clock arbiter sharing one dual-port RAM (separate write and read ports, registered read with valid) between two requesters, A and B. Write and read ports are arbitrated independently with round-robin fairness, so one requester can write while the other reads in the same cycle. The block registers the RAM command signals and routes each returned read word back to the requester that issued it. It sits between two client engines and the RAM instance, with all three on one clock.

## Interface
- WIDTH, 16: data word width.
- DEPTH, 256: RAM depth; address width AW = $clog2(DEPTH).
- RD_LATENCY, 1: cycles from RAM read enable to RAM read valid.

- i_Clk  in  1  sole clock, rising edge.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Req_A / i_Req_B  in  1  request valid; held until granted.
- i_Wr_A / i_Wr_B  in  1  1 = write, 0 = read; stable while request held.
- i_Addr_A / i_Addr_B  in  AW  address.
- i_Data_A / i_Data_B  in  WIDTH  write data; ignored for reads.
- o_Gnt_A / o_Gnt_B  out  1  request accepted this cycle (combinational).
- o_Rd_DV_A / o_Rd_DV_B  out  1  one-cycle read-data-valid pulse.
- o_Rd_Data_A / o_Rd_Data_B  out  WIDTH  read data; held between pulses.
- o_Wr_DV  out  1  RAM write strobe.
- o_Wr_Addr  out  AW  RAM write address.
- o_Wr_Data  out  WIDTH  RAM write data.
- o_Rd_En  out  1  RAM read enable.
- o_Rd_Addr  out  AW  RAM read address.
- i_Rd_DV  in  1  RAM read valid.
- i_Rd_Data  in  WIDTH  RAM read data.

## Operation
- Two independent arbiters: the write arbiter sees requesters with Req&Wr; the read arbiter sees requesters with Req&!Wr.
- Per arbiter, one requester → granted; both → granted to the priority-pointer holder.
- After any grant on a port, that port's pointer moves to the other requester. It is unchanged on idle cycles. Both pointers reset to A.
- A write grant and a read grant can occur in the same cycle for different requesters. One requester never receives two grants in a cycle.
- Handshake: a request is accepted in a cycle with Req=1 and Gnt=1. The requester may change address/data/op or drop Req in the next cycle. Without Gnt, the requester holds Req and all fields stable.
- Owner tracking: on each read grant, the owner ID (A=0, B=1) enters a RD_LATENCY+1-deep tag shift register together with a valid bit.
- On i_Rd_DV=1, the tag at the pipeline output selects the destination. The block drives that requester's o_Rd_DV_x=1 for one cycle with o_Rd_Data_x=i_Rd_Data, registered.
- i_Rd_DV=1 with the tag valid=0 is an error. The data is dropped, and no o_Rd_DV_x pulse occurs.
- Same-address write and read issued in the same cycle: the read returns the pre-write data, because the RAM is read-first. The arbiter does no forwarding.
- Reset (asynchronous, mid-operation included): o_Gnt_x combinationally 0. Registered outputs go to o_Wr_DV=0, o_Rd_En=0, o_Wr_Addr=0, o_Wr_Data=0, o_Rd_Addr=0, o_Rd_DV_x=0, o_Rd_Data_x=0. The tag pipeline clears, and in-flight reads are discarded with no pulse after reset release.

## Timing
- Cycle N: Gnt. Cycle N+1: o_Wr_DV/o_Rd_En asserted with address/data (registered). Command outputs are 0 in cycles without a grant.
- Read: RAM valid at N+1+RD_LATENCY; o_Rd_DV_x at N+2+RD_LATENCY (N+3 for default).
- Throughput: one write and one read per cycle total. Under continuous contention, each requester gets every second grant on each port.
- Back-to-back reads from alternating owners return in issue order, with one pulse per cycle.

## Structure
- Package ram_arb_pkg: OWNER_A=1'b0, OWNER_B=1'b1; OP_RD=1'b0, OP_WR=1'b1.
- Sub-module rr_arb2: 2-way round-robin with pointer register, request[1:0] → grant[1:0] one-hot. Instantiated twice (write and read).
- Top level contains the command registers, the tag shift register and the read-return demux.

## Test plan
- Reset then A writes 0x1234 @0x05 alone: Gnt_A in cycle N; o_Wr_DV=1, addr 0x05, data 0x1234 at N+1; B untouched.
- A and B both write continuously (A @0x10 0xAAAA, B @0x11 0xBBBB): grants alternate A,B,A,B starting with A; each request granted within 2 cycles.
- A writes 0x00C3 @0x20 while B reads 0x20 in the same cycle: both granted. B receives the old value. B's next read of 0x20 returns 0x00C3 on o_Rd_DV_B three cycles after its grant.
- Alternating reads A@1, B@2, A@3 with RAM preloaded to 0x0101/0x0202/0x0303: o_Rd_DV_A, o_Rd_DV_B, o_Rd_DV_A pulse on consecutive cycles with the matching data; the other requester's DV stays 0.
- Assert i_Rst_L=0 one cycle after a read grant: all outputs 0 immediately. After release, no o_Rd_DV_x pulses, and the first contended grant goes to A.
- Inject i_Rd_DV=1 with no read outstanding: no o_Rd_DV_x pulse, and o_Rd_Data_x is unchanged.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the two-port RAM arbiter slice.
//   owner_t   : which requester a transaction belongs to (A=0, B=1)
//   op_t      : request operation encoding (read=0, write=1)
//   rd_tag_t  : one stage of the read-owner tracking pipeline
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A read grant leaves one of these behind so the returning word can be
  // steered to whoever asked for it.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester is granted immediately;
// when both request, the priority pointer decides, and after every grant
// the pointer moves to the requester that was not served.
// Ports:
//   i_Clk    : clock, rising edge
//   i_Rst_L  : asynchronous active-low reset (pointer back to A)
//   i_Req    : request vector, bit 0 = A, bit 1 = B
//   o_Gnt    : one-hot (or zero) grant, combinational from i_Req
// ---------------------------------------------------------------------------
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_Req,
  output logic [1:0] o_Gnt
);

  owner_t r_Ptr;

  // Grant decode: only a tie consults the pointer.
  always_comb begin
    o_Gnt = 2'b00;
    case (i_Req)
      2'b01:   o_Gnt = 2'b01;
      2'b10:   o_Gnt = 2'b10;
      2'b11:   o_Gnt = (r_Ptr == OWNER_B) ? 2'b10 : 2'b01;
      default: o_Gnt = 2'b00;
    endcase
  end

  // Pointer hands priority to the other side after any grant and holds
  // through idle cycles.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Ptr <= OWNER_A;
    end else if (o_Gnt[0]) begin
      r_Ptr <= OWNER_B;
    end else if (o_Gnt[1]) begin
      r_Ptr <= OWNER_A;
    end
  end

endmodule

// File: rtl/ram_2port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_2port_arbiter
// Shares one dual-port RAM (separate write port, registered read port with
// valid) between requesters A and B. Write and read ports are arbitrated
// independently, so A may write while B reads in the same cycle. Commands
// to the RAM are registered; returned read words are routed back to the
// requester that issued them using a tag pipeline.
// Ports:
//   i_Clk, i_Rst_L                 : clock / async active-low reset
//   i_Req_x, i_Wr_x                : request valid, 1=write 0=read
//   i_Addr_x, i_Data_x             : address, write data
//   o_Gnt_x                        : request accepted this cycle (comb.)
//   o_Rd_DV_x, o_Rd_Data_x         : read return pulse and held data
//   o_Wr_DV, o_Wr_Addr, o_Wr_Data  : RAM write port
//   o_Rd_En, o_Rd_Addr             : RAM read command
//   i_Rd_DV, i_Rd_Data             : RAM read return
// ---------------------------------------------------------------------------
module ram_2port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Req_A,
  input  logic             i_Wr_A,
  input  logic [AW-1:0]    i_Addr_A,
  input  logic [WIDTH-1:0] i_Data_A,
  input  logic             i_Req_B,
  input  logic             i_Wr_B,
  input  logic [AW-1:0]    i_Addr_B,
  input  logic [WIDTH-1:0] i_Data_B,
  output logic             o_Gnt_A,
  output logic             o_Gnt_B,
  output logic             o_Rd_DV_A,
  output logic [WIDTH-1:0] o_Rd_Data_A,
  output logic             o_Rd_DV_B,
  output logic [WIDTH-1:0] o_Rd_Data_B,
  output logic             o_Wr_DV,
  output logic [AW-1:0]    o_Wr_Addr,
  output logic [WIDTH-1:0] o_Wr_Data,
  output logic             o_Rd_En,
  output logic [AW-1:0]    o_Rd_Addr,
  input  logic             i_Rd_DV,
  input  logic [WIDTH-1:0] i_Rd_Data
);

  logic [1:0] w_Wr_Req;
  logic [1:0] w_Rd_Req;
  logic [1:0] w_Wr_Gnt;
  logic [1:0] w_Rd_Gnt;
  rd_tag_t    w_New_Tag;
  rd_tag_t    w_Out_Tag;
  rd_tag_t    r_Tag [RD_LATENCY+1];

  // Requests are masked while reset is held so grants drop to zero
  // immediately, not just at the next edge.
  assign w_Wr_Req = {i_Req_B & (i_Wr_B == OP_WR), i_Req_A & (i_Wr_A == OP_WR)}
                    & {2{i_Rst_L}};
  assign w_Rd_Req = {i_Req_B & (i_Wr_B == OP_RD), i_Req_A & (i_Wr_A == OP_RD)}
                    & {2{i_Rst_L}};

  rr_arb2 u_wr_arb (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Req   (w_Wr_Req),
    .o_Gnt   (w_Wr_Gnt)
  );

  rr_arb2 u_rd_arb (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Req   (w_Rd_Req),
    .o_Gnt   (w_Rd_Gnt)
  );

  // A requester is either writing or reading, so at most one of the two
  // arbiters can grant it in a given cycle.
  assign o_Gnt_A = w_Wr_Gnt[0] | w_Rd_Gnt[0];
  assign o_Gnt_B = w_Wr_Gnt[1] | w_Rd_Gnt[1];

  // Write command register: strobe, address and data are all zero in any
  // cycle that follows a cycle without a write grant.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Wr_DV   <= 1'b0;
      o_Wr_Addr <= '0;
      o_Wr_Data <= '0;
    end else begin
      o_Wr_DV   <= |w_Wr_Gnt;
      o_Wr_Addr <= '0;
      o_Wr_Data <= '0;
      if (w_Wr_Gnt[1]) begin
        o_Wr_Addr <= i_Addr_B;
        o_Wr_Data <= i_Data_B;
      end else if (w_Wr_Gnt[0]) begin
        o_Wr_Addr <= i_Addr_A;
        o_Wr_Data <= i_Data_A;
      end
    end
  end

  // Read command register, same zero-when-idle behaviour as the write side.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Rd_En   <= 1'b0;
      o_Rd_Addr <= '0;
    end else begin
      o_Rd_En   <= |w_Rd_Gnt;
      o_Rd_Addr <= '0;
      if (w_Rd_Gnt[1]) begin
        o_Rd_Addr <= i_Addr_B;
      end else if (w_Rd_Gnt[0]) begin
        o_Rd_Addr <= i_Addr_A;
      end
    end
  end

  assign w_New_Tag.valid = |w_Rd_Gnt;
  assign w_New_Tag.owner = w_Rd_Gnt[1] ? OWNER_B : OWNER_A;

  // Tag pipeline: stage 0 is loaded at the grant edge, alongside o_Rd_En,
  // so stage RD_LATENCY lines up with the cycle the RAM raises i_Rd_DV.
  // A bubble (valid=0) is shifted in on cycles without a read grant.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i <= RD_LATENCY; i++) begin
        r_Tag[i] <= '0;
      end
    end else begin
      r_Tag[0] <= w_New_Tag;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        r_Tag[i] <= r_Tag[i-1];
      end
    end
  end

  assign w_Out_Tag = r_Tag[RD_LATENCY];

  // Read-return demux: a RAM valid without a matching tag is treated as
  // spurious and dropped, leaving both held data registers untouched.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Rd_DV_A   <= 1'b0;
      o_Rd_DV_B   <= 1'b0;
      o_Rd_Data_A <= '0;
      o_Rd_Data_B <= '0;
    end else begin
      o_Rd_DV_A <= 1'b0;
      o_Rd_DV_B <= 1'b0;
      if (i_Rd_DV && w_Out_Tag.valid) begin
        if (w_Out_Tag.owner == OWNER_B) begin
          o_Rd_DV_B   <= 1'b1;
          o_Rd_Data_B <= i_Rd_Data;
        end else begin
          o_Rd_DV_A   <= 1'b1;
          o_Rd_Data_A <= i_Rd_Data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_2port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_2port_arbiter
// Directed, table-driven bench for ram_2port_arbiter with a small read-first
// RAM model (RD_LATENCY=1) hooked to the RAM ports, plus hand-written
// sequences for mid-operation reset and a spurious RAM valid.
// ---------------------------------------------------------------------------
module tb_ram_2port_arbiter;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        clk = 1'b0;
  logic        rstL = 1'b1;
  logic        reqA = 1'b0, wrA = 1'b0, reqB = 1'b0, wrB = 1'b0;
  logic [7:0]  addrA = '0, addrB = '0;
  logic [15:0] dataA = '0, dataB = '0;
  logic        gntA, gntB, rdDvA, rdDvB, wrDv, rdEn;
  logic [15:0] rdDataA, rdDataB, wrData;
  logic [7:0]  wrAddr, rdAddr;
  logic        ramRdDv;
  logic [15:0] ramRdData;

  // RAM model state plus an injection path for a spurious read valid.
  logic [15:0] mem [256];
  logic        memInit = 1'b0;
  logic        ramDv = 1'b0;
  logic [15:0] ramData = '0;
  logic        injDv = 1'b0;
  logic [15:0] injData = '0;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    bit          reqA; bit wrA; logic [7:0] addrA; logic [15:0] dataA;
    bit          reqB; bit wrB; logic [7:0] addrB; logic [15:0] dataB;
    bit          gntA; bit gntB;
    bit          wrDv; logic [7:0] wrAddr; logic [15:0] wrData;
    bit          rdEn; logic [7:0] rdAddr;
    bit          rdDvA; bit rdDvB; logic [15:0] rdDataA; logic [15:0] rdDataB;
  } vec_t;

  vec_t tbl [23];

  ram_2port_arbiter #(.WIDTH(16), .DEPTH(256), .RD_LATENCY(1)) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rstL),
    .i_Req_A     (reqA),
    .i_Wr_A      (wrA),
    .i_Addr_A    (addrA),
    .i_Data_A    (dataA),
    .i_Req_B     (reqB),
    .i_Wr_B      (wrB),
    .i_Addr_B    (addrB),
    .i_Data_B    (dataB),
    .o_Gnt_A     (gntA),
    .o_Gnt_B     (gntB),
    .o_Rd_DV_A   (rdDvA),
    .o_Rd_Data_A (rdDataA),
    .o_Rd_DV_B   (rdDvB),
    .o_Rd_Data_B (rdDataB),
    .o_Wr_DV     (wrDv),
    .o_Wr_Addr   (wrAddr),
    .o_Wr_Data   (wrData),
    .o_Rd_En     (rdEn),
    .o_Rd_Addr   (rdAddr),
    .i_Rd_DV     (ramRdDv),
    .i_Rd_Data   (ramRdData)
  );

  always #5 clk = ~clk;

  // Read-first RAM: the read samples the old contents even when the same
  // edge writes that address. Preload happens on the first edge.
  always @(posedge clk) begin
    if (!memInit) begin
      mem[8'h01] <= 16'h0101;
      mem[8'h02] <= 16'h0202;
      mem[8'h03] <= 16'h0303;
      mem[8'h20] <= 16'h5555;
      memInit    <= 1'b1;
    end
    if (rdEn) ramData <= mem[rdAddr];
    ramDv <= rdEn;
    if (wrDv) mem[wrAddr] <= wrData;
  end

  assign ramRdDv   = ramDv | injDv;
  assign ramRdData = injDv ? injData : ramData;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives the requester inputs for one cycle.
  task automatic applyStimulus(input vec_t v);
    reqA = v.reqA; wrA = v.wrA; addrA = v.addrA; dataA = v.dataA;
    reqB = v.reqB; wrB = v.wrB; addrB = v.addrB; dataB = v.dataB;
  endtask

  // Checks every DUT output against one table row.
  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.gntA", i),    {15'd0, gntA},  {15'd0, v.gntA});
    checkOutput($sformatf("v%0d.gntB", i),    {15'd0, gntB},  {15'd0, v.gntB});
    checkOutput($sformatf("v%0d.wrDv", i),    {15'd0, wrDv},  {15'd0, v.wrDv});
    checkOutput($sformatf("v%0d.wrAddr", i),  {8'd0, wrAddr}, {8'd0, v.wrAddr});
    checkOutput($sformatf("v%0d.wrData", i),  wrData,         v.wrData);
    checkOutput($sformatf("v%0d.rdEn", i),    {15'd0, rdEn},  {15'd0, v.rdEn});
    checkOutput($sformatf("v%0d.rdAddr", i),  {8'd0, rdAddr}, {8'd0, v.rdAddr});
    checkOutput($sformatf("v%0d.rdDvA", i),   {15'd0, rdDvA}, {15'd0, v.rdDvA});
    checkOutput($sformatf("v%0d.rdDvB", i),   {15'd0, rdDvB}, {15'd0, v.rdDvB});
    checkOutput($sformatf("v%0d.rdDataA", i), rdDataA,        v.rdDataA);
    checkOutput($sformatf("v%0d.rdDataB", i), rdDataB,        v.rdDataB);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".gntA"},    {15'd0, gntA},  16'h0);
    checkOutput({tag, ".gntB"},    {15'd0, gntB},  16'h0);
    checkOutput({tag, ".wrDv"},    {15'd0, wrDv},  16'h0);
    checkOutput({tag, ".wrAddr"},  {8'd0, wrAddr}, 16'h0);
    checkOutput({tag, ".wrData"},  wrData,         16'h0);
    checkOutput({tag, ".rdEn"},    {15'd0, rdEn},  16'h0);
    checkOutput({tag, ".rdAddr"},  {8'd0, rdAddr}, 16'h0);
    checkOutput({tag, ".rdDvA"},   {15'd0, rdDvA}, 16'h0);
    checkOutput({tag, ".rdDvB"},   {15'd0, rdDvB}, 16'h0);
    checkOutput({tag, ".rdDataA"}, rdDataA,        16'h0);
    checkOutput({tag, ".rdDataB"}, rdDataB,        16'h0);
  endtask

  task automatic setIdle();
    reqA = 1'b0; wrA = 1'b0; addrA = '0; dataA = '0;
    reqB = 1'b0; wrB = 1'b0; addrB = '0; dataB = '0;
  endtask

  initial begin
    // Each row: inputs for the cycle, then outputs expected in that cycle.
    //          reqA wrA addrA  dataA     reqB wrB addrB  dataB     gA gB  wDv wAddr  wData     rEn rAddr  dvA dvB dataA     dataB
    // A writes alone, then B alone to pass the write pointer back to A.
    tbl[0]  = '{Y, Y, 8'h05, 16'h1234, N, N, 8'h00, 16'h0000, Y, N, N, 8'h00, 16'h0000, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[1]  = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, Y, 8'h05, 16'h1234, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[2]  = '{N, N, 8'h00, 16'h0000, Y, Y, 8'h30, 16'h0030, N, Y, N, 8'h00, 16'h0000, N, 8'h00, N, N, 16'h0000, 16'h0000};
    // Continuous write contention: A,B,A,B then A alone for its held request.
    tbl[3]  = '{Y, Y, 8'h10, 16'hAAAA, Y, Y, 8'h11, 16'hBBBB, Y, N, Y, 8'h30, 16'h0030, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[4]  = '{Y, Y, 8'h10, 16'hAAAA, Y, Y, 8'h11, 16'hBBBB, N, Y, Y, 8'h10, 16'hAAAA, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[5]  = '{Y, Y, 8'h10, 16'hAAAA, Y, Y, 8'h11, 16'hBBBB, Y, N, Y, 8'h11, 16'hBBBB, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[6]  = '{Y, Y, 8'h10, 16'hAAAA, Y, Y, 8'h11, 16'hBBBB, N, Y, Y, 8'h10, 16'hAAAA, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[7]  = '{Y, Y, 8'h10, 16'hAAAA, N, N, 8'h00, 16'h0000, Y, N, Y, 8'h11, 16'hBBBB, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[8]  = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, Y, 8'h10, 16'hAAAA, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[9]  = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, N, 8'h00, 16'h0000, N, 8'h00, N, N, 16'h0000, 16'h0000};
    // A writes 0x00C3 @0x20 while B reads 0x20: old 0x5555 first, then new.
    tbl[10] = '{Y, Y, 8'h20, 16'h00C3, Y, N, 8'h20, 16'h0000, Y, Y, N, 8'h00, 16'h0000, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[11] = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, Y, 8'h20, 16'h00C3, Y, 8'h20, N, N, 16'h0000, 16'h0000};
    tbl[12] = '{N, N, 8'h00, 16'h0000, Y, N, 8'h20, 16'h0000, N, Y, N, 8'h00, 16'h0000, N, 8'h00, N, N, 16'h0000, 16'h0000};
    tbl[13] = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, N, 8'h00, 16'h0000, Y, 8'h20, N, Y, 16'h0000, 16'h5555};
    tbl[14] = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, N, 8'h00, 16'h0000, N, 8'h00, N, N, 16'h0000, 16'h5555};
    tbl[15] = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, N, 8'h00, 16'h0000, N, 8'h00, N, Y, 16'h0000, 16'h00C3};
    // Alternating reads A@1, B@2, A@3 under read-port contention.
    tbl[16] = '{Y, N, 8'h01, 16'h0000, Y, N, 8'h02, 16'h0000, Y, N, N, 8'h00, 16'h0000, N, 8'h00, N, N, 16'h0000, 16'h00C3};
    tbl[17] = '{Y, N, 8'h03, 16'h0000, Y, N, 8'h02, 16'h0000, N, Y, N, 8'h00, 16'h0000, Y, 8'h01, N, N, 16'h0000, 16'h00C3};
    tbl[18] = '{Y, N, 8'h03, 16'h0000, N, N, 8'h00, 16'h0000, Y, N, N, 8'h00, 16'h0000, Y, 8'h02, N, N, 16'h0000, 16'h00C3};
    tbl[19] = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, N, 8'h00, 16'h0000, Y, 8'h03, Y, N, 16'h0101, 16'h00C3};
    tbl[20] = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, N, 8'h00, 16'h0000, N, 8'h00, N, Y, 16'h0101, 16'h0202};
    tbl[21] = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, N, 8'h00, 16'h0000, N, 8'h00, Y, N, 16'h0303, 16'h0202};
    tbl[22] = '{N, N, 8'h00, 16'h0000, N, N, 8'h00, 16'h0000, N, N, N, 8'h00, 16'h0000, N, 8'h00, N, N, 16'h0303, 16'h0202};

    // Power-on reset.
    #2 rstL = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("por");
    @(posedge clk); #1;
    rstL = 1'b1;

    // Table-driven section.
    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkVector(i, tbl[i]);
    end

    // Mid-operation reset: B read granted, reset asserted the next cycle
    // with contended writes pending.
    @(posedge clk); #1;
    reqA = 1'b1; wrA = 1'b1; addrA = 8'h40; dataA = 16'h0001;
    reqB = 1'b1; wrB = 1'b0; addrB = 8'h05; dataB = 16'h0000;
    @(negedge clk);
    checkOutput("rst.preGntA", {15'd0, gntA}, 16'h1);
    checkOutput("rst.preGntB", {15'd0, gntB}, 16'h1);
    @(posedge clk); #1;
    rstL = 1'b0;
    reqA = 1'b1; wrA = 1'b1; addrA = 8'h10; dataA = 16'hAAAA;
    reqB = 1'b1; wrB = 1'b1; addrB = 8'h11; dataB = 16'hBBBB;
    #1;
    checkAllZero("rst.now");
    @(posedge clk);
    @(negedge clk);
    checkAllZero("rst.held");
    rstL = 1'b1;
    #1;
    checkOutput("rst.relGntA", {15'd0, gntA}, 16'h1);
    checkOutput("rst.relGntB", {15'd0, gntB}, 16'h0);
    // A was accepted; B keeps its request and a stray RAM valid arrives.
    @(posedge clk); #1;
    reqA = 1'b0; wrA = 1'b0;
    injDv = 1'b1; injData = 16'hBEEF;
    @(negedge clk);
    checkOutput("rst.gntB2", {15'd0, gntB}, 16'h1);
    checkOutput("rst.wrAddr", {8'd0, wrAddr}, 16'h0010);
    @(posedge clk); #1;
    setIdle();
    injDv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst.post%0d.rdDvA", c), {15'd0, rdDvA}, 16'h0);
      checkOutput($sformatf("rst.post%0d.rdDvB", c), {15'd0, rdDvB}, 16'h0);
      @(posedge clk); #1;
    end

    // Spurious RAM valid with nothing outstanding after a real A read.
    reqA = 1'b1; wrA = 1'b0; addrA = 8'h01;
    @(negedge clk);
    checkOutput("inj.gntA", {15'd0, gntA}, 16'h1);
    @(posedge clk); #1;
    setIdle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("inj.rdDvA", {15'd0, rdDvA}, 16'h1);
    checkOutput("inj.rdDataA", rdDataA, 16'h0101);
    @(posedge clk); #1;
    injDv = 1'b1; injData = 16'hDEAD;
    @(posedge clk); #1;
    injDv = 1'b0;
    @(negedge clk);
    checkOutput("inj.noDvA", {15'd0, rdDvA}, 16'h0);
    checkOutput("inj.noDvB", {15'd0, rdDvB}, 16'h0);
    checkOutput("inj.keepA", rdDataA, 16'h0101);
    checkOutput("inj.keepB", rdDataB, 16'h0000);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
